twiddle_fetch_seq: RTL and testbench

Sequencer that reads the stage-indexed twiddle ROM pair (real and imaginary, shared address, one-cycle registered read) and streams the twiddle words to the butterfly datapath over a valid/ready interface. One `start` pulse walks the whole ROM address range in order. ROM latency and downstream back-pressure are absorbed in a 2-entry output buffer with credit-based address issue, so throughput is one twiddle per cycle while `tw_ready` is high. The block sits between the twiddle ROMs and the IFFT/FFT butterfly stage controller.

---
 rtl/twiddle_fetch_seq.sv | 157 +++++++++++++++
 tb/tb_twiddle_fetch_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_fetch_seq.sv
// Streams the twiddle ROM pair (re/im, one-cycle registered read) to the butterfly
// datapath over valid/ready, with a 2-entry output buffer and credit-based address issue.
module twiddle_fetch_seq #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int NUM_ENTRIES = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re_data,
  input  logic [DATA_W-1:0] rom_im_data,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic              tw_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head_re_q, head_re_d, head_im_q, head_im_d;
  logic [DATA_W-1:0] tail_re_q, tail_re_d, tail_im_q, tail_im_d;
  logic              head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic              done_q, done_d;
  logic              pop, issue;

  assign pop = (occ_q != 2'd0) && tw_ready;
  // Credit: buffered + in-flight entries, less the one leaving now, must leave room.
  assign issue = (state_q == RUN) &&
                 ((3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);

  always_comb begin
    state_d         = state_q;
    addr_cnt_d      = addr_cnt_q;
    inflight_d      = issue;
    inflight_last_d = issue && (addr_cnt_q == LAST_ADDR);
    occ_d           = occ_q;
    head_re_d       = head_re_q;
    head_im_d       = head_im_q;
    head_last_d     = head_last_q;
    tail_re_d       = tail_re_q;
    tail_im_d       = tail_im_q;
    tail_last_d     = tail_last_q;
    done_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          addr_cnt_d = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (addr_cnt_q == LAST_ADDR) state_d = DRAIN;
          else                         addr_cnt_d = addr_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (pop && head_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_re_d   = rom_re_data;
          head_im_d   = rom_im_data;
          head_last_d = inflight_last_q;
        end else begin
          tail_re_d   = rom_re_data;
          tail_im_d   = rom_im_data;
          tail_last_d = inflight_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_re_d   = tail_re_q;
        head_im_d   = tail_im_q;
        head_last_d = tail_last_q;
        occ_d       = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_re_d   = rom_re_data;
          head_im_d   = rom_im_data;
          head_last_d = inflight_last_q;
        end else begin
          head_re_d   = tail_re_q;
          head_im_d   = tail_im_q;
          head_last_d = tail_last_q;
          tail_re_d   = rom_re_data;
          tail_im_d   = rom_im_data;
          tail_last_d = inflight_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      head_re_q       <= '0;
      head_im_q       <= '0;
      head_last_q     <= 1'b0;
      tail_re_q       <= '0;
      tail_im_q       <= '0;
      tail_last_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_cnt_q      <= addr_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      head_re_q       <= head_re_d;
      head_im_q       <= head_im_d;
      head_last_q     <= head_last_d;
      tail_re_q       <= tail_re_d;
      tail_im_q       <= tail_im_d;
      tail_last_q     <= tail_last_d;
      done_q          <= done_d;
    end
  end

  assign rom_addr = addr_cnt_q;
  assign tw_re    = head_re_q;
  assign tw_im    = head_im_q;
  assign tw_valid = (occ_q != 2'd0);
  assign tw_last  = tw_valid && head_last_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight_q && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Scoreboard bench for twiddle_fetch_seq: a reference model queues the expected
// twiddle stream per accepted start; a negedge monitor checks every transfer.
module tb_twiddle_fetch_seq;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NE = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          tw_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_re_data, rom_im_data, tw_re, tw_im;
  logic          tw_valid, tw_last, busy, done;

  logic          start1 = 1'b0;
  logic          tw_ready1 = 1'b1;
  logic [AW-1:0] rom_addr1;
  logic [DW-1:0] rom_re1, rom_im1, tw_re1, tw_im1;
  logic          tw_valid1, tw_last1, busy1, done1;

  logic [DW-1:0] re_tab [32];
  logic [DW-1:0] im_tab [32];

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int xfer_total = 0;
  int done_total = 0;
  bit model_busy = 1'b0;
  bit last_xfer_prev = 1'b0;
  bit stall_prev = 1'b0;
  bit mon_accept, mon_xfer;
  exp_t mon_e;
  logic [DW-1:0] hold_re, hold_im;
  logic hold_last;

  twiddle_fetch_seq #(.ADDR_W(AW), .DATA_W(DW), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr),
    .rom_re_data(rom_re_data), .rom_im_data(rom_im_data),
    .tw_re(tw_re), .tw_im(tw_im), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_last(tw_last), .busy(busy), .done(done)
  );

  twiddle_fetch_seq #(.ADDR_W(AW), .DATA_W(DW), .NUM_ENTRIES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rom_addr(rom_addr1),
    .rom_re_data(rom_re1), .rom_im_data(rom_im1),
    .tw_re(tw_re1), .tw_im(tw_im1), .tw_valid(tw_valid1), .tw_ready(tw_ready1),
    .tw_last(tw_last1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // Behavioural ROM pair: registered read of the presented address.
  always @(posedge clk) begin
    rom_re_data <= re_tab[rom_addr];
    rom_im_data <= im_tab[rom_addr];
    rom_re1     <= re_tab[rom_addr1];
    rom_im1     <= im_tab[rom_addr1];
  end

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((model_busy || exp_q.size() != 0 || busy) && n < bound) begin
      tick();
      n++;
    end
    chk_eq("idle_within_bound", 64'(busy), 64'(0));
    chk_eq("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_busy     = 1'b0;
      last_xfer_prev = 1'b0;
      stall_prev     = 1'b0;
    end else begin
      chk_eq("busy", 64'(busy), 64'(model_busy));
      chk_eq("done", 64'(done), 64'(last_xfer_prev));
      if (done) done_total++;
      if (stall_prev) begin
        chk_eq("hold_valid", 64'(tw_valid), 64'(1));
        chk_eq("hold_data", 64'({tw_re, tw_im, tw_last}), 64'({hold_re, hold_im, hold_last}));
      end
      mon_accept     = start && !model_busy;
      mon_xfer       = tw_valid && tw_ready;
      last_xfer_prev = 1'b0;
      if (mon_xfer) begin
        xfer_total++;
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_xfer", 64'(tw_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("tw_re", 64'(tw_re), 64'(mon_e.re));
          chk_eq("tw_im", 64'(tw_im), 64'(mon_e.im));
          chk_eq("tw_last", 64'(tw_last), 64'(mon_e.last));
          last_xfer_prev = mon_e.last;
          if (mon_e.last) model_busy = 1'b0;
        end
      end
      stall_prev = tw_valid && !tw_ready;
      hold_re    = tw_re;
      hold_im    = tw_im;
      hold_last  = tw_last;
      if (mon_accept) begin
        for (int i = 0; i < NE; i++) exp_q.push_back('{re_tab[i], im_tab[i], (i == NE - 1)});
        model_busy = 1'b1;
      end
    end
  end

  initial begin
    int x0, d0, n;
    for (int i = 0; i < 32; i++) begin
      re_tab[i] = DW'($urandom);
      im_tab[i] = DW'($urandom);
    end
    im_tab[9]  = 16'h00B5;
    im_tab[24] = 16'h0100;
    im_tab[27] = 16'h00FD;

    #1;
    chk_eq("rst_tw_valid", 64'(tw_valid), 64'(0));
    chk_eq("rst_tw_last", 64'(tw_last), 64'(0));
    chk_eq("rst_tw_data", 64'({tw_re, tw_im}), 64'(0));
    chk_eq("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk_eq("rst_busy_done", 64'({busy, done}), 64'(0));
    #20 rst = 1'b0;

    // Full-rate run with two ignored restart pulses.
    tw_ready = 1'b1;
    d0 = done_total;
    x0 = xfer_total;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    chk_eq("c1_rom_addr", 64'(rom_addr), 64'(0));
    chk_eq("c1_busy", 64'(busy), 64'(1));
    tick();
    chk_eq("c2_tw_valid", 64'(tw_valid), 64'(0));
    chk_eq("c2_rom_addr", 64'(rom_addr), 64'(1));
    tick();
    chk_eq("c3_tw_valid", 64'(tw_valid), 64'(1));
    chk_eq("c3_entry0_im", 64'(tw_im), 64'(im_tab[0]));
    repeat (2) tick();
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (6) tick();
    chk_eq("entry9_im", 64'(tw_im), 64'(16'h00B5));
    repeat (8) tick();
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (6) tick();
    chk_eq("entry24_im", 64'(tw_im), 64'(16'h0100));
    repeat (2) tick();
    chk_eq("c29_not_last", 64'({tw_valid, tw_last}), 64'(2'b10));
    tick();
    chk_eq("entry27_im", 64'(tw_im), 64'(16'h00FD));
    chk_eq("c30_last", 64'(tw_last), 64'(1));
    tick();
    chk_eq("c31_done", 64'(done), 64'(1));
    chk_eq("c31_busy", 64'(busy), 64'(0));
    tick();
    chk_eq("one_done", 64'(done_total - d0), 64'(1));
    chk_eq("xfer_count", 64'(xfer_total - x0), 64'(NE));

    // Back-pressure from start until cycle 10.
    tw_ready = 1'b0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int c = 3; c <= 10; c++) begin
      tick();
      chk_eq("stall_rom_addr", 64'(rom_addr), 64'(2));
      chk_eq("stall_valid", 64'(tw_valid), 64'(1));
      chk_eq("stall_entry0_re", 64'(tw_re), 64'(re_tab[0]));
    end
    tick();
    tw_ready = 1'b1;
    x0 = xfer_total;
    repeat (NE) tick();
    chk_eq("release_rate", 64'(xfer_total - x0), 64'(NE));
    wait_idle(50);

    // Reset mid-run with the buffer full at entry 12.
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    x0 = xfer_total;
    n = 0;
    while ((xfer_total - x0) < 12 && n < 100) begin
      tick();
      n++;
    end
    tw_ready = 1'b0;
    repeat (3) tick();
    chk_eq("head_entry12_re", 64'(tw_re), 64'(re_tab[12]));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_valid_last", 64'({tw_valid, tw_last}), 64'(0));
    chk_eq("arst_data", 64'({tw_re, tw_im}), 64'(0));
    chk_eq("arst_busy_done", 64'({busy, done}), 64'(0));
    chk_eq("arst_rom_addr", 64'(rom_addr), 64'(0));
    tick();
    rst = 1'b0;
    tw_ready = 1'b1;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    wait_idle(60);

    // Random back-pressure and random (often ignored) start pulses.
    for (int i = 0; i < 1000; i++) begin
      tick();
      tw_ready = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 9) == 0);
    end
    tick();
    start = 1'b0;
    tw_ready = 1'b1;
    wait_idle(200);

    // Single-entry instance.
    tick(); start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk_eq("n1_c1_busy", 64'(busy1), 64'(1));
    tick();
    chk_eq("n1_c2_busy_valid", 64'({busy1, tw_valid1}), 64'(2'b10));
    tick();
    chk_eq("n1_c3_valid_last", 64'({tw_valid1, tw_last1}), 64'(2'b11));
    chk_eq("n1_c3_im", 64'(tw_im1), 64'(im_tab[0]));
    chk_eq("n1_c3_re", 64'(tw_re1), 64'(re_tab[0]));
    tick();
    chk_eq("n1_c4_done", 64'(done1), 64'(1));
    chk_eq("n1_c4_busy_valid", 64'({busy1, tw_valid1}), 64'(0));
    tick();
    chk_eq("n1_c5_done_low", 64'(done1), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
